// File: rtl/fan_tach_capture.sv
// ---------------------------------------------------------------------------
// fan_tach_capture
//
// Measures fan revolution time from an open-drain tachometer line. The result
// is the number of clk_en_i ticks per revolution. It shares its prescaler
// enable with the fan PWM controller, so periods are in PWM counter ticks.
//
// Ports
//   clk_i     in   system clock
//   rstn_i    in   asynchronous active-low reset
//   clk_en_i  in   prescaler tick; sampling, filtering and counting only here
//   tach_i    in   raw tach line, asynchronous to clk_i, idles high
//   period_o  out  ticks per revolution, saturates at all-ones
//   valid_o   out  one clk_i pulse whenever period_o/stall_o update
//   stall_o   out  high until a valid revolution has been measured
// ---------------------------------------------------------------------------
module fan_tach_capture #(
    parameter int TACH_BITWIDTH  = 12,
    parameter int FILTER_DEPTH   = 3,
    parameter int PULSES_PER_REV = 2
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     clk_en_i,
    input  logic                     tach_i,
    output logic [TACH_BITWIDTH-1:0] period_o,
    output logic                     valid_o,
    output logic                     stall_o
);

    localparam int FCNT_W = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
    localparam int NCNT_W = (PULSES_PER_REV > 1) ? $clog2(PULSES_PER_REV) : 1;

    localparam logic [TACH_BITWIDTH-1:0] PMAX      = '1;
    localparam logic [FCNT_W-1:0]        FCNT_LAST = FCNT_W'(FILTER_DEPTH - 1);
    localparam logic [NCNT_W-1:0]        NCNT_LAST = NCNT_W'(PULSES_PER_REV - 1);

    localparam logic [0:0] ST_ARM     = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    // Saturating increment of the period counter.
    function automatic logic [TACH_BITWIDTH-1:0] sat_inc(input logic [TACH_BITWIDTH-1:0] v);
        if (v == PMAX) begin
            return PMAX;
        end
        return v + 1'b1;
    endfunction

    logic                     r_tach_sync_p0;
    logic                     r_tach_sync_p1;
    logic                     r_filt;
    logic [FCNT_W-1:0]        r_fcnt;
    logic [0:0]               r_state;
    logic [TACH_BITWIDTH-1:0] r_pcnt;
    logic [NCNT_W-1:0]        r_ncnt;
    logic [TACH_BITWIDTH-1:0] r_period;
    logic                     r_valid;
    logic                     r_stall;
    logic                     w_s;
    logic                     w_edge;

    // Stage p0/p1: two-flop synchronizer, runs every clk_i, idles high.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_tach_sync_p0 <= 1'b1;
            r_tach_sync_p1 <= 1'b1;
        end else begin
            r_tach_sync_p0 <= tach_i;
            r_tach_sync_p1 <= r_tach_sync_p0;
        end
    end

    assign w_s = r_tach_sync_p1;

    // Glitch filter: filt follows s only after FILTER_DEPTH consecutive
    // enabled samples that disagree with it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_filt <= 1'b1;
            r_fcnt <= '0;
        end else if (clk_en_i) begin
            if (w_s == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FCNT_LAST) begin
                r_filt <= w_s;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    // Falling edge of filt, seen in the same tick the filter commits it.
    assign w_edge = clk_en_i & r_filt & ~w_s & (r_fcnt == FCNT_LAST);

    // Measurement FSM. pcnt counts ticks since the opening edge of the
    // current revolution; the closing edge also opens the next one.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= ST_ARM;
            r_pcnt   <= '0;
            r_ncnt   <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_stall  <= 1'b1;
        end else begin
            r_valid <= 1'b0;
            if (clk_en_i) begin
                case (r_state)
                    ST_ARM: begin
                        if (w_edge) begin
                            r_state <= ST_MEASURE;
                            r_pcnt  <= '0;
                            r_ncnt  <= '0;
                        end
                    end
                    default: begin
                        // An edge beats a stall on the same tick.
                        if (w_edge) begin
                            if (r_ncnt == NCNT_LAST) begin
                                r_period <= sat_inc(r_pcnt);
                                r_valid  <= 1'b1;
                                r_stall  <= 1'b0;
                                r_pcnt   <= '0;
                                r_ncnt   <= '0;
                            end else begin
                                r_ncnt <= r_ncnt + 1'b1;
                                r_pcnt <= sat_inc(r_pcnt);
                            end
                        end else if (r_pcnt == PMAX) begin
                            r_period <= PMAX;
                            r_valid  <= 1'b1;
                            r_stall  <= 1'b1;
                            r_state  <= ST_ARM;
                        end else begin
                            r_pcnt <= r_pcnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign period_o = r_period;
    assign valid_o  = r_valid;
    assign stall_o  = r_stall;

endmodule

// File: doc/fan_tach_capture.md
# fan_tach_capture

Measures fan revolution time from the fan's open-drain tachometer line and reports it as a count of `clk_en_i` ticks per revolution. It is the feedback stage downstream of the fan PWM controller and uses the same prescaler enable, so its period units match the PWM counter tick. Outputs are `period_o`, a one-cycle `valid_o` strobe and a `stall_o` flag. The closed-loop speed logic that computes the next duty value reads these outputs.

## Interface
- `TACH_BITWIDTH`, 12: width of the period counter and of `period_o`.
- `FILTER_DEPTH`, 3: number of consecutive equal enabled samples needed to change the filtered tach level (≥2).
- `PULSES_PER_REV`, 2: tach falling edges per revolution (≥1).

Ports:
- `clk_i`  in  1  system clock.
- `rstn_i`  in  1  reset. Asynchronous assert, active-low. Release is synchronous to `clk_i` upstream.
- `clk_en_i`  in  1  prescaler tick. Only these cycles sample, count and detect edges.
- `tach_i`  in  1  raw tach line. Asynchronous to `clk_i`, idles high.
- `period_o`  out  `TACH_BITWIDTH`  ticks per revolution. Saturates at all-ones.
- `valid_o`  out  1  one `clk_i` pulse when `period_o` updates.
- `stall_o`  out  1  high when no valid revolution has been measured since reset or since the last stall.

## Operation
- **Synchronizer.** Two flops clocked every `clk_i`, both reset to 1. `s` is the second flop's output.
- **Glitch filter.**
  - Registered level `filt` (reset 1) and counter `fcnt` (reset 0).
  - On a `clk_en_i` cycle with `s == filt`: `fcnt <= 0`.
  - On a `clk_en_i` cycle with `s != filt` and `fcnt < FILTER_DEPTH-1`: `fcnt <= fcnt+1`.
  - On a `clk_en_i` cycle with `s != filt` and `fcnt == FILTER_DEPTH-1`: `filt <= s` and `fcnt <= 0`.
- **Edge strobe.** `edge` is combinational and is true in a `clk_en_i` cycle where `filt` goes 1→0. Rising transitions are ignored.
- **FSM states.** ARM (reset state) and MEASURE. Registers are a period counter `pcnt` (saturating, reset 0) and pulse counter `ncnt` (reset 0).
- **ARM.**
  - `edge` → MEASURE, `pcnt <= 0`, `ncnt <= 0`.
  - No counting happens in ARM, so no stall is detected.
- **MEASURE, `clk_en_i` cycle with `edge`.**
  - If `ncnt == PULSES_PER_REV-1` (closing edge): `period_o <= sat(pcnt+1)`, `valid_o <= 1`, `stall_o <= 0`, `pcnt <= 0`, `ncnt <= 0`.
  - Otherwise: `ncnt <= ncnt+1` and `pcnt <= sat(pcnt+1)`.
- **MEASURE, `clk_en_i` cycle without `edge`.**
  - `pcnt < max`: `pcnt <= pcnt+1`.
  - `pcnt == max` (stall): `period_o <= max`, `valid_o <= 1`, `stall_o <= 1`, → ARM.
- **Arithmetic and priority.**
  - `max` = 2^TACH_BITWIDTH − 1. `sat` clamps to `max`.
  - An edge on the same tick as a stall condition wins: the measurement is normal, with `period_o` saturated.
- **Cycles with `clk_en_i` = 0.** Only the synchronizer advances. All other state holds.
- **Reset values.** `period_o` = 0, `valid_o` = 0, `stall_o` = 1, state ARM, `filt` = 1.
- **Reset mid-measurement.** The partial count is discarded. The next revolution is measured from the first edge after release.

## Timing
- `valid_o` is registered and high for exactly one `clk_i` cycle, during the cycle after the deciding clock edge.
- `period_o` and `stall_o` change on that same clock edge and hold until the next update.
- **Edge latency, `clk_en_i` tied high.**
  - `tach_i` low before clock edge 0: the sync output is low after edge 1.
  - Samples are taken at edges 2 .. FILTER_DEPTH+1.
  - `filt` falls and the strobe is acted on at edge FILTER_DEPTH+1. With default depth this is edge 4, and `valid_o` is high after edge 4 if the edge is a closing one.
- **Measurement semantics.**
  - `period_o` = number of `clk_en_i` ticks from the opening edge's tick to the closing edge's tick.
  - Example: opening edge at tick 0, closing at tick 200 → 200.
- **Stall timing.** A stall is declared at the 2^TACH_BITWIDTH-th tick after the last edge when no edge occurs on that tick.
- **Pulse width limits.**
  - Low or high pulses shorter than FILTER_DEPTH enabled samples never reach `filt`.
  - A pulse of exactly FILTER_DEPTH samples is accepted.

## Test plan
- **Square wave.** `clk_en_i`=1, tach 50 ticks low / 50 ticks high, PPR=2 → first `valid_o` at the 3rd filtered falling edge with `period_o`=200. `stall_o` goes 1→0 then. Each subsequent 2-edge revolution gives 200 again.
- **Glitch rejection.** Tach held high with a 2-tick low glitch (depth 3) → no `valid_o`, `filt` stays 1. A 3-tick low pulse → edge accepted and the FSM leaves ARM.
- **Stall.** Tach held high after one edge, `TACH_BITWIDTH`=12 → at tick 4096 `valid_o`=1, `period_o`=4095, `stall_o`=1, state ARM. Resuming the 100-tick wave → valid 200 and `stall_o`=0.
- **Saturation tie.** Closing edge lands exactly on tick 4096 → `period_o`=4095, `stall_o`=0.
- **Prescaled enable.** `clk_en_i` every 4th `clk_i`, tach edges 400 `clk_i` apart, PPR=1 → `period_o`=100. `valid_o` stays one `clk_i` wide.
- **Reset mid-measurement.** Assert `rstn_i` mid-revolution → outputs immediately read 0/0/1. After release, the first `valid_o` comes only after PPR+1 edges, with the correct period.
